// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared FSM state type and default frame width
package serial_frame_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } state_t;
endpackage

// File: rtl/serial_frame_receiver_frame_out_reg.sv
// frame_out_reg: output holding register with valid/ready handshake and sticky overrun flag
module frame_out_reg
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              commit_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              byte_ready_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              overrun_o
);
  logic drop;
  logic consume;
  assign consume = byte_valid_o && byte_ready_i;
  assign drop    = commit_i && byte_valid_o && !byte_ready_i;
  // load a committed frame unless the previous one is still unconsumed; a new overrun beats a clear
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (commit_i && !drop) begin
        byte_o       <= data_i;
        byte_valid_o <= 1'b1;
      end else if (consume) begin
        byte_valid_o <= 1'b0;
      end
      overrun_o <= drop ? 1'b1 : (err_clr_i ? 1'b0 : overrun_o);
    end
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: LSB-first serial frame deserializer with error detection; FRAME_CNT_EN adds frame_cnt_o
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              new_data_i,
  input  logic              done_shifting_i,
  input  logic              data_i,
  input  logic              byte_ready_i,
  input  logic              err_clr_i,
  output logic [DATA_W-1:0] byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o,
  output logic              overrun_o,
`ifdef FRAME_CNT_EN
  output logic [7:0]        frame_cnt_o,
`endif
  output logic [1:0]        current_state_o
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t            state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shifted;
  logic              commit;
  logic              restart;
  assign shifted         = {data_i, sreg[DATA_W-1:1]};
  assign commit          = en_i && state == COMMIT && done_shifting_i;
  assign restart         = !done_shifting_i && new_data_i;
  assign current_state_o = state;
  // frame FSM and shifter; every step waits on en_i except recovery from the unused encoding
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE:
          if (en_i && new_data_i) begin
            sreg  <= shifted;
            cnt   <= CW'(1);
            state <= SHIFT;
          end
        SHIFT:
          if (en_i) begin
            if (new_data_i) begin
              frame_err_o <= 1'b1;
              sreg        <= shifted;
              cnt         <= CW'(1);
            end else if (done_shifting_i) begin
              frame_err_o <= 1'b1;
              cnt         <= '0;
              state       <= IDLE;
            end else begin
              sreg  <= shifted;
              cnt   <= cnt + CW'(1);
              state <= (cnt == CW'(DATA_W - 1)) ? COMMIT : SHIFT;
            end
          end
        COMMIT:
          if (en_i) begin
            frame_err_o <= !done_shifting_i;
            cnt         <= restart ? CW'(1) : '0;
            sreg        <= restart ? shifted : sreg;
            state       <= restart ? SHIFT : IDLE;
          end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
`ifdef FRAME_CNT_EN
  // counts every completed frame, including those dropped by an overrun
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) frame_cnt_o <= '0;
    else if (commit) frame_cnt_o <= frame_cnt_o + 8'd1;
`endif
  frame_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .commit_i    (commit),
    .data_i      (sreg),
    .byte_ready_i(byte_ready_i),
    .err_clr_i   (err_clr_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .overrun_o   (overrun_o)
  );
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed vector table, reset/stall sequences and randomized model comparison
module tb_serial_frame_receiver;
  localparam int W = 8;
  logic clk = 1'b0, rst_i = 1'b0, en_i = 1'b0, new_data_i = 1'b0, done_shifting_i = 1'b0;
  logic data_i = 1'b0, byte_ready_i = 1'b0, err_clr_i = 1'b0;
  logic [W-1:0] byte_o;
  logic byte_valid_o, frame_err_o, overrun_o;
  logic [1:0] current_state_o;
`ifdef FRAME_CNT_EN
  logic [7:0] frame_cnt_o;
`endif
  int checks = 0, failures = 0;

  serial_frame_receiver #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .new_data_i(new_data_i),
    .done_shifting_i(done_shifting_i), .data_i(data_i), .byte_ready_i(byte_ready_i),
    .err_clr_i(err_clr_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o),
`ifdef FRAME_CNT_EN
    .frame_cnt_o(frame_cnt_o),
`endif
    .current_state_o(current_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, nd, dn, d, rdy, clr;
    logic [7:0] eb;
    logic ev, ee, eo;
    logic [1:0] es;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, nd, dn, d, rdy, clr);
    en_i = en; new_data_i = nd; done_shifting_i = dn; data_i = d;
    byte_ready_i = rdy; err_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_i = 0; new_data_i = 0; done_shifting_i = 0; data_i = 0; byte_ready_i = 0; err_clr_i = 0;
    rst_i = 1;
    @(posedge clk);
    #1;
    rst_i = 0;
  endtask

  task automatic add(input logic en, nd, dn, d, rdy, clr, input logic [7:0] eb,
                     input logic ev, ee, eo, input logic [1:0] es);
    tv.push_back('{en, nd, dn, d, rdy, clr, eb, ev, ee, eo, es});
  endtask

  task automatic add_frame(input logic [7:0] v, input int n, input logic [7:0] eb, input logic ev, eo);
    for (int i = 0; i < n; i++)
      add(1, i == 0, 0, v[i], 0, 0, eb, ev, 0, eo, (i == W - 1) ? 2'd2 : 2'd1);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rdy);
    for (int i = 0; i < W; i++) drive(1, i == 0, 0, v[i], 0, 0);
    drive(1, 0, 1, 0, rdy, 0);
  endtask

  int q[$];
  bit act;
  logic [7:0] m_byte;
  bit m_v, m_e, m_o;
  int m_cnt;

  task automatic model_reset();
    q = {}; act = 0; m_byte = 0; m_v = 0; m_e = 0; m_o = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic en, nd, dn, d, rdy, clr);
    bit commit, drop;
    int val;
    commit = 0; val = 0; m_e = 0;
    if (en) begin
      if (!act) begin
        if (nd) begin q = {}; q.push_back(int'(d)); act = 1; end
      end else if (q.size() < W) begin
        if (nd) begin m_e = 1; q = {}; q.push_back(int'(d)); end
        else if (dn) begin m_e = 1; q = {}; act = 0; end
        else q.push_back(int'(d));
      end else if (dn) begin
        commit = 1;
        foreach (q[i]) val += q[i] << i;
        q = {}; act = 0;
      end else begin
        m_e = 1;
        q = {};
        if (nd) q.push_back(int'(d)); else act = 0;
      end
    end
    drop = commit && m_v && !rdy;
    m_o = drop ? 1 : (clr ? 0 : m_o);
    if (commit && !drop) begin m_byte = val[7:0]; m_v = 1; end
    else if (m_v && rdy) m_v = 0;
    m_cnt = (m_cnt + int'(commit)) % 256;
  endtask

  task automatic step(input logic en, nd, dn, d, rdy, clr);
    int es;
    drive(en, nd, dn, d, rdy, clr);
    model_step(en, nd, dn, d, rdy, clr);
    es = !act ? 0 : (q.size() < W ? 1 : 2);
    chk("rnd byte", int'(byte_o), int'(m_byte));
    chk("rnd valid", int'(byte_valid_o), int'(m_v));
    chk("rnd err", int'(frame_err_o), int'(m_e));
    chk("rnd overrun", int'(overrun_o), int'(m_o));
    chk("rnd state", int'(current_state_o), es);
`ifdef FRAME_CNT_EN
    chk("rnd cnt", int'(frame_cnt_o), m_cnt);
`endif
  endtask

  initial begin
    do_reset();
    chk("reset byte", int'(byte_o), 0);
    chk("reset valid", int'(byte_valid_o), 0);
    chk("reset state", int'(current_state_o), 0);
    chk("reset overrun", int'(overrun_o), 0);

    add_frame(8'hA5, 8, 8'h00, 0, 0);
    add(1, 0, 1, 0, 0, 0, 8'hA5, 1, 0, 0, 0);
    add_frame(8'hFF, 5, 8'hA5, 1, 0);
    add(1, 0, 1, 0, 0, 0, 8'hA5, 1, 1, 0, 0);
    add(1, 0, 1, 0, 1, 0, 8'hA5, 0, 0, 0, 0);
    add_frame(8'h3C, 8, 8'hA5, 0, 0);
    add(1, 0, 1, 0, 0, 0, 8'h3C, 1, 0, 0, 0);
    add_frame(8'hC3, 8, 8'h3C, 1, 0);
    add(1, 0, 1, 0, 0, 0, 8'h3C, 1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 1, 8'h3C, 1, 0, 0, 0);
    add_frame(8'h5A, 8, 8'h3C, 1, 0);
    add(1, 0, 1, 0, 1, 0, 8'h5A, 1, 0, 0, 0);
    add_frame(8'h11, 8, 8'h5A, 1, 0);
    add(1, 0, 0, 0, 0, 0, 8'h5A, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 8'h5A, 1, 0, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].en, tv[i].nd, tv[i].dn, tv[i].d, tv[i].rdy, tv[i].clr);
      chk($sformatf("tv%0d byte", i), int'(byte_o), int'(tv[i].eb));
      chk($sformatf("tv%0d valid", i), int'(byte_valid_o), int'(tv[i].ev));
      chk($sformatf("tv%0d err", i), int'(frame_err_o), int'(tv[i].ee));
      chk($sformatf("tv%0d overrun", i), int'(overrun_o), int'(tv[i].eo));
      chk($sformatf("tv%0d state", i), int'(current_state_o), int'(tv[i].es));
    end

    for (int i = 0; i < 4; i++) drive(1, i == 0, 0, 1, 0, 0);
    chk("pre-reset state", int'(current_state_o), 1);
    #1 rst_i = 1;
    #1;
    chk("async rst byte", int'(byte_o), 0);
    chk("async rst valid", int'(byte_valid_o), 0);
    chk("async rst state", int'(current_state_o), 0);
    chk("async rst err", int'(frame_err_o), 0);
    @(posedge clk);
    #1 rst_i = 0;
    send_byte(8'h81, 0);
    chk("post-rst byte", int'(byte_o), 8'h81);
    chk("post-rst valid", int'(byte_valid_o), 1);
    chk("post-rst err", int'(frame_err_o), 0);

    do_reset();
    for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 1'((8'hA5 >> i) & 1), 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1'(i), 0, 0);
      chk("stall state", int'(current_state_o), 1);
      chk("stall err", int'(frame_err_o), 0);
    end
    for (int i = 3; i < W; i++) drive(1, 0, 0, 1'((8'hA5 >> i) & 1), 0, 0);
    chk("stall commit state", int'(current_state_o), 2);
    drive(1, 0, 1, 0, 0, 0);
    chk("stall byte", int'(byte_o), 8'hA5);
    chk("stall valid", int'(byte_valid_o), 1);
`ifdef FRAME_CNT_EN
    chk("stall cnt", int'(frame_cnt_o), 1);
`endif

    do_reset();
    model_reset();
    for (int f = 0; f < 150; f++) begin
      int len;
      len = ($urandom % 4 != 0) ? W : int'($urandom_range(1, W + 1));
      for (int i = 0; i < len; i++) begin
        while ($urandom % 6 == 0)
          step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        step(1, i == 0 || $urandom % 25 == 0, 0, 1'($urandom), 1'($urandom), $urandom % 16 == 0);
      end
      step(1, 0, 1, 1'($urandom), 1'($urandom), $urandom % 16 == 0);
      repeat ($urandom % 3) step(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
